// File: rtl/cache_l2_param.sv
// cache_l2_param: direct-mapped, write-through L2 with read allocation and an L1 sub-block export.
// Defining CACHE_L2_PARAM_STATS_EN adds the hit_count/miss_count statistics outputs.
module cache_l2_param #(
    parameter int LINES    = 8,
    parameter int WORDS    = 8,
    parameter int L1_WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            addr,
    input  logic                   renable,
    input  logic                   wenable,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   stall,
    output logic [32*L1_WORDS-1:0] l1block,
    output logic                   mem_renable,
    output logic                   mem_wenable,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_ready
`ifdef CACHE_L2_PARAM_STATS_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    localparam int WB  = $clog2(WORDS);
    localparam int OFF = WB + 2;
    localparam int IDX = $clog2(LINES);
    localparam int TAG = 32 - IDX - OFF;

    localparam logic [WB:0]   CNT_LAST = (WB + 1)'(WORDS - 1);
    localparam logic [WB-1:0] BLK_MASK = ~WB'(L1_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t           state_q, state_d;
    logic [WB:0]      cnt_q, cnt_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [IDX-1:0]   fill_idx_q, fill_idx_d;
    logic [TAG-1:0]   fill_tag_q, fill_tag_d;
    logic             mem_renable_q, mem_renable_d;
    logic             mem_wenable_q, mem_wenable_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic [31:0]    data_q [LINES][WORDS];
    logic [TAG-1:0] tag_q  [LINES];

    logic [TAG-1:0] a_tag;
    logic [IDX-1:0] a_idx;
    logic [WB-1:0]  a_word;
    logic [WB-1:0]  blk_base;
    logic           hit;
    logic           unused_addr_bits;

    logic           data_we;
    logic           tag_we;
    logic [IDX-1:0] data_idx;
    logic [WB-1:0]  data_word;
    logic [31:0]    data_wdata;

    assign a_tag            = addr[31:OFF+IDX];
    assign a_idx            = addr[OFF+IDX-1:OFF];
    assign a_word           = addr[OFF-1:2];
    assign blk_base         = a_word & BLK_MASK;
    assign unused_addr_bits = ^addr[1:0];

    assign hit   = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign rdata = data_q[a_idx][a_word];

    // Word 0 of the aligned sub-block lands in the most significant slot.
    always_comb begin
        l1block = '0;
        for (int unsigned i = 0; i < L1_WORDS; i++) begin
            l1block[32*(L1_WORDS-1-i) +: 32] = data_q[a_idx][blk_base + WB'(i)];
        end
    end

    always_comb begin
        stall = 1'b1;
        if (rst) begin
            stall = renable;
        end else begin
            case (state_q)
                IDLE:    stall = renable ? !hit : wenable;
                FILL:    stall = 1'b1;
                WRITE:   stall = !mem_ready;
                default: stall = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        fill_idx_d    = fill_idx_q;
        fill_tag_d    = fill_tag_q;
        mem_renable_d = mem_renable_q;
        mem_wenable_d = mem_wenable_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        data_we       = 1'b0;
        tag_we        = 1'b0;
        data_idx      = a_idx;
        data_word     = a_word;
        data_wdata    = wdata;
        case (state_q)
            IDLE: begin
                if (renable) begin
                    if (!hit) begin
                        valid_d[a_idx] = 1'b0;
                        fill_idx_d     = a_idx;
                        fill_tag_d     = a_tag;
                        cnt_d          = '0;
                        mem_renable_d  = 1'b1;
                        mem_addr_d     = {addr[31:OFF], {OFF{1'b0}}};
                        state_d        = FILL;
                    end
                end else if (wenable) begin
                    data_we       = hit;
                    mem_wenable_d = 1'b1;
                    mem_addr_d    = {addr[31:2], 2'b00};
                    mem_wdata_d   = wdata;
                    state_d       = WRITE;
                end
            end
            FILL: begin
                if (mem_ready) begin
                    data_we    = 1'b1;
                    data_idx   = fill_idx_q;
                    data_word  = cnt_q[WB-1:0];
                    data_wdata = mem_rdata;
                    if (cnt_q == CNT_LAST) begin
                        valid_d[fill_idx_q] = 1'b1;
                        tag_we              = 1'b1;
                        cnt_d               = '0;
                        mem_renable_d       = 1'b0;
                        mem_addr_d          = '0;
                        state_d             = IDLE;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    mem_wenable_d = 1'b0;
                    mem_addr_d    = '0;
                    mem_wdata_d   = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            valid_q       <= '0;
            fill_idx_q    <= '0;
            fill_tag_q    <= '0;
            mem_renable_q <= 1'b0;
            mem_wenable_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            fill_idx_q    <= fill_idx_d;
            fill_tag_q    <= fill_tag_d;
            mem_renable_q <= mem_renable_d;
            mem_wenable_q <= mem_wenable_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[data_idx][data_word] <= data_wdata;
        end
        if (tag_we) begin
            tag_q[fill_idx_q] <= fill_tag_q;
        end
    end

    assign mem_renable = mem_renable_q;
    assign mem_wenable = mem_wenable_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

`ifdef CACHE_L2_PARAM_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && renable) begin
            if (hit) begin
                hit_count_d = hit_count_q + 32'd1;
            end else begin
                miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cache_l2_param.sv
// Scoreboard bench for cache_l2_param: directed reads/writes against a word-addressed memory model.
module tb_cache_l2_param;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         renable;
    logic         wenable;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic [127:0] l1block;
    logic         mem_renable;
    logic         mem_wenable;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = '0;
    logic         mem_ready = 1'b1;
`ifdef CACHE_L2_PARAM_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int mode        = 0;
    int ph          = 0;

    logic [31:0] exp_q[$];
    logic [31:0] fill_log[$];
    logic [31:0] mem_img[logic [31:0]];
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    cache_l2_param #(.LINES(8), .WORDS(8), .L1_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .renable     (renable),
        .wenable     (wenable),
        .wdata       (wdata),
        .rdata       (rdata),
        .stall       (stall),
        .l1block     (l1block),
        .mem_renable (mem_renable),
        .mem_wenable (mem_wenable),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
`ifdef CACHE_L2_PARAM_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] lookup(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 32'hA5A5_A5A5;
    endfunction

    // Memory responder: mode 0 zero-wait, 1 ready on alternate busy cycles, 2 two wait cycles.
    always @(posedge clk) begin
        #1;
        if (mem_renable || mem_wenable) begin
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ph[0];
                default: mem_ready = (ph >= 2);
            endcase
            ph++;
        end else begin
            ph        = 0;
            mem_ready = (mode == 0);
        end
        mem_rdata = lookup(mem_addr);
    end

    // Monitor: pops the scoreboard on every completed read and watches the memory side.
    always @(negedge clk) begin
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            if (renable && !stall) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected: read of %h completed with no expected value queued", addr);
                end else begin
                    check("sb_rdata", rdata, exp_q.pop_front());
                end
            end
            if (mem_renable || mem_wenable) check("mem_exclusive", mem_renable && mem_wenable, 0);
            if (mem_renable && prev_wait) check("fill_addr_hold", mem_addr, prev_addr);
            prev_wait = mem_renable && !mem_ready;
            prev_addr = mem_addr;
            if (mem_renable && mem_ready) fill_log.push_back(mem_addr);
            if (mem_wenable && mem_ready) mem_img[mem_addr] = mem_wdata;
        end
    end

    task automatic do_reset();
        rst     = 1'b1;
        renable = 1'b0;
        wenable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp,
                           input int exp_stalls);
        int st = 0;
        bit done = 1'b0;
        addr    = a;
        renable = 1'b1;
        exp_q.push_back(exp);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else st++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: stall still high after %0d cycles, required low", name, st);
        end
        check({name, "_stalls"}, st, exp_stalls);
        @(posedge clk);
        #1 renable = 1'b0;
    endtask

    task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d,
                            input int exp_stalls);
        int st = 0;
        bit done = 1'b0;
        addr    = a;
        wdata   = d;
        wenable = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                if (st > 0) begin
                    check({name, "_mem_wen"}, mem_wenable, 1);
                    check({name, "_mem_addr"}, mem_addr, a);
                    check({name, "_mem_wdata"}, mem_wdata, d);
                end
                st++;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: stall still high after %0d cycles, required low", name, st);
        end
        check({name, "_ack_wen"}, mem_wenable, 1);
        check({name, "_stalls"}, st, exp_stalls);
        @(posedge clk);
        #1 wenable = 1'b0;
    endtask

    task automatic check_fill(input string name, input logic [31:0] base);
        check({name, "_fill_count"}, fill_log.size(), 8);
        for (int i = 0; i < 8 && i < fill_log.size(); i++) begin
            check({name, "_fill_addr"}, fill_log[i], base + 32'(4 * i));
        end
        fill_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "global timeout");
    end

    initial begin
        rst     = 1'b1;
        renable = 1'b0;
        wenable = 1'b0;
        addr    = '0;
        wdata   = '0;

        // Reset state: stall mirrors renable, memory side quiet.
        @(posedge clk);
        #1 renable = 1'b1;
        @(negedge clk);
        check("rst_stall", stall, 1);
        check("rst_mem_ren", mem_renable, 0);
        check("rst_mem_wen", mem_wenable, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        renable = 1'b0;
        @(negedge clk);
        check("idle_stall", stall, 0);
        @(posedge clk);
        #1;

        // Cold miss, zero-wait memory, then a repeat hit and L1 sub-block export.
        fill_log.delete();
        do_read("cold_miss", 32'h0000_0124, 32'hA5A5_A481, 9);
        check_fill("cold", 32'h0000_0120);
        do_read("cold_hit", 32'h0000_0124, 32'hA5A5_A481, 0);
        addr = 32'h0000_0124;
        @(negedge clk);
        check("l1block_lo", l1block, {32'hA5A5_A485, 32'hA5A5_A481, 32'hA5A5_A48D, 32'hA5A5_A489});
        @(posedge clk);
        #1 addr = 32'h0000_0138;
        @(negedge clk);
        check("l1block_hi", l1block, {32'hA5A5_A495, 32'hA5A5_A491, 32'hA5A5_A49D, 32'hA5A5_A499});
        @(posedge clk);
        #1;

        // Same cold miss with alternate-cycle wait states.
        mode = 1;
        do_reset();
        fill_log.delete();
        do_read("wait_miss", 32'h0000_0124, 32'hA5A5_A481, 17);
        check_fill("wait", 32'h0000_0120);
        mode = 0;

        // Conflict eviction: same index, different tag.
        do_reset();
        do_read("conf_a", 32'h0000_0120, 32'hA5A5_A485, 9);
        do_read("conf_b", 32'h0000_0420, 32'hA5A5_A185, 9);
        do_read("conf_a2", 32'h0000_0120, 32'hA5A5_A485, 9);

        // Write hit with two wait cycles, then a non-allocating write miss.
        mode = 2;
        do_write("wr_hit", 32'h0000_0128, 32'hDEAD_BEEF, 3);
        mode = 0;
        do_read("rd_wr_hit", 32'h0000_0128, 32'hDEAD_BEEF, 0);
        do_write("wr_miss", 32'h0000_0820, 32'h1111_1111, 1);
        do_read("rd_after_wmiss", 32'h0000_0128, 32'hDEAD_BEEF, 0);
        fill_log.delete();
        do_read("rd_wmiss_line", 32'h0000_0820, 32'h1111_1111, 9);
        check_fill("wmiss", 32'h0000_0820);

        // Reset during fill word 3, then a full refill of the same address.
        addr    = 32'h0000_0244;
        renable = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midfill_addr", mem_addr, 32'h0000_024C);
        check("midfill_ren", mem_renable, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        renable = 1'b0;
        @(negedge clk);
        check("postrst_ren", mem_renable, 0);
        check("postrst_stall", stall, 0);
        @(posedge clk);
        #1;
        do_read("refill", 32'h0000_0244, 32'hA5A5_A7E1, 9);

`ifdef CACHE_L2_PARAM_STATS_EN
        do_reset();
        do_read("st_miss", 32'h0000_0300, 32'hA5A5_A6A5, 9);
        do_read("st_hit1", 32'h0000_0300, 32'hA5A5_A6A5, 0);
        do_read("st_hit2", 32'h0000_0304, 32'hA5A5_A6A1, 0);
        do_read("st_hit3", 32'h0000_0300, 32'hA5A5_A6A5, 0);
        @(negedge clk);
        check("miss_count", miss_count, 1);
        check("hit_count", hit_count, 4);
        @(posedge clk);
        #1;
`endif

        repeat (2) @(posedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
